// File: rtl/latch_bank_pkg.sv
// -----------------------------------------------------------------------------
// latch_bank_pkg
// Shared definitions for the latch-bank write arbiter:
//   - state_e   : write-sequencer states (IDLE, SETUP, OPEN, HOLD)
//   - *_DEF     : default parameter values used by latch_bank_arb
// No ports (package).
// -----------------------------------------------------------------------------
package latch_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int NREQ_DEF = 4;   // requesters
    localparam int AW_DEF   = 3;   // latch-bank address width
    localparam int DW_DEF   = 8;   // latch data width

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. The search starts at last_winner+1 and
// wraps, so the previous winner has the lowest priority.
// Ports:
//   req         in  NREQ  request vector
//   last_winner in  LW    index of the previous winner
//   winner      out NREQ  one-hot selected requester (zero when req == 0)
//   winner_idx  out LW    binary index of the selected requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int LW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last_winner,
    output logic [NREQ-1:0] winner,
    output logic [LW-1:0]   winner_idx
);

    logic [NREQ-1:0] mask_hi;
    logic [NREQ-1:0] upper;
    logic [NREQ-1:0] pick;
    logic            any_req;

    // Requesters strictly above the last winner are searched first; if none of
    // them is requesting, the search wraps to the low end (which includes the
    // last winner itself, giving it the lowest priority).
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mask
            assign mask_hi[gi] = (LW'(gi) > last_winner);
        end
    endgenerate

    assign upper   = req & mask_hi;
    assign pick    = (|upper) ? upper : req;
    assign any_req = |req;

    // Lowest set bit of pick; descending scan so the last hit is the lowest.
    always_comb begin
        winner_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick[i]) begin
                winner_idx = LW'(i);
            end
        end
    end

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign winner[gi] = any_req && (winner_idx == LW'(gi));
        end
    endgenerate

endmodule

// File: rtl/latch_bank_arb.sv
// -----------------------------------------------------------------------------
// latch_bank_arb
// Arbitrates NREQ write requesters onto a bank of 2**AW transparent latches.
// Each write is sequenced IDLE -> SETUP -> OPEN [-> HOLD] -> IDLE so that the
// shared data bus is stable before the single enable opens and after it closes.
//
// Build option: macro LATCH_BANK_ARB_HOLD_EN
//   defined   : HOLD state present, done pulses in HOLD (4 cycles per write)
//   undefined : OPEN returns straight to IDLE, done pulses in OPEN (3 cycles)
//
// Ports:
//   clock      in   1          sole clock, rising edge
//   reset      in   1          synchronous active-high reset
//   req        in   NREQ       level write requests
//   req_addr   in   NREQ*AW    packed target entry per requester
//   req_data   in   NREQ*DW    packed write data per requester
//   gnt        out  NREQ       one-hot grant, high during SETUP
//   done       out  NREQ       one-hot completion pulse
//   busy       out  1          high whenever the sequencer is not IDLE
//   lat_ena_n  out  2**AW      active-low latch enables, at most one low
//   lat_data   out  DW         shared latch data bus
// -----------------------------------------------------------------------------
module latch_bank_arb
    import latch_bank_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [(2**AW)-1:0]   lat_ena_n,
    output logic [DW-1:0]        lat_data
);

    localparam int NENT = 2 ** AW;
    localparam int LW   = $clog2(NREQ);

`ifdef LATCH_BANK_ARB_HOLD_EN
    localparam state_e DONE_ST = HOLD;
`else
    localparam state_e DONE_ST = OPEN;
`endif

    state_e          state_q, state_d;
    logic [LW-1:0]   last_q,  last_d;
    logic [NREQ-1:0] win_q,   win_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [DW-1:0]   data_q,  data_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic [NREQ-1:0] done_q,  done_d;
    logic [NENT-1:0] ena_n_q, ena_n_d;

    logic [NREQ-1:0] arb_winner;
    logic [LW-1:0]   arb_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    rr_arbiter #(
        .NREQ (NREQ),
        .LW   (LW)
    ) u_rr (
        .req         (req),
        .last_winner (last_q),
        .winner      (arb_winner),
        .winner_idx  (arb_idx)
    );

    // One-hot mux of the winning requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_winner[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= LW'(NREQ - 1);
            win_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            ena_n_q <= '1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ena_n_q <= ena_n_d;
        end
    end

    // Next-state logic; the request is captured only on IDLE -> SETUP so later
    // changes on req/req_addr/req_data cannot disturb a write in flight.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = SETUP;
                    last_d  = arb_idx;
                    win_d   = arb_winner;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                end
            end
            SETUP: state_d = OPEN;
`ifdef LATCH_BANK_ARB_HOLD_EN
            OPEN:  state_d = HOLD;
`else
            OPEN:  state_d = IDLE;
`endif
            HOLD:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic, decoded from the next state so every strobe leaves a flop.
    always_comb begin
        gnt_d   = '0;
        done_d  = '0;
        ena_n_d = '1;
        if (state_d == SETUP) begin
            gnt_d = win_d;
        end
        if (state_d == DONE_ST) begin
            done_d = win_q;
        end
        if (state_d == OPEN) begin
            ena_n_d[addr_q] = 1'b0;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign lat_ena_n = ena_n_q;
    assign lat_data  = data_q;   // only reloaded on capture, so held in IDLE
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_latch_bank_arb.sv
// -----------------------------------------------------------------------------
// tb_latch_bank_arb
// Directed bench for latch_bank_arb (NREQ=4, AW=3, DW=8). Follows the
// LATCH_BANK_ARB_HOLD_EN build option for write length and done timing.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_latch_bank_arb;

    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int DW   = 8;
    localparam int NENT = 8;
`ifdef LATCH_BANK_ARB_HOLD_EN
    localparam int WCYC = 4;
`else
    localparam int WCYC = 3;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [NENT-1:0]   lat_ena_n;
    logic [DW-1:0]     lat_data;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    always #5 clock = ~clock;

    latch_bank_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .lat_ena_n (lat_ena_n),
        .lat_data  (lat_data)
    );

    // Per-cycle invariants: at most one enable low, enables low only while
    // busy and not granting (i.e. OPEN), gnt/done one-hot or zero.
    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if (($countones(~lat_ena_n) > 1) || !$onehot0(gnt) || !$onehot0(done) ||
                ((lat_ena_n != 8'hFF) && (!busy || gnt != 4'b0000))) begin
                errors++;
                $display("FAIL invariant: ena_n=%b gnt=%b done=%b busy=%b (need <=1 enable low, only in OPEN; gnt/done one-hot0)",
                         lat_ena_n, gnt, done, busy);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        req = '0; req_addr = '0; req_data = '0;
        reset = 1'b1;
        tick(2);
        mon_en = 1'b1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (lat_ena_n !== 8'hFF) begin errors++; $display("FAIL reset_ena: got %b want 11111111", lat_ena_n); end
        checks++; if (lat_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", lat_data); end
        reset = 1'b0;
        tick(2);
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || lat_ena_n !== 8'hFF) begin
            errors++; $display("FAIL idle_noreq: busy=%b gnt=%b ena=%b want 0/0000/11111111", busy, gnt, lat_ena_n);
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    // Single write from requester 0, addr 5, data A5; req dropped after grant.
    task automatic test_single_write;
        set_src(0, 3'd5, 8'hA5);
        req = 4'b0001;
        tick(1);   // SETUP
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL sw_gnt: got %b want 0001", gnt); end
        checks++; if (lat_ena_n !== 8'hFF || lat_data !== 8'hA5 || busy !== 1'b1) begin
            errors++; $display("FAIL sw_setup: ena=%b data=%h busy=%b want 11111111/a5/1", lat_ena_n, lat_data, busy);
        end
        req = 4'b0000;
        tick(1);   // OPEN
        checks++; if (lat_ena_n !== 8'b1101_1111 || lat_data !== 8'hA5 || gnt !== 4'b0000) begin
            errors++; $display("FAIL sw_open: ena=%b data=%h gnt=%b want 11011111/a5/0000", lat_ena_n, lat_data, gnt);
        end
`ifdef LATCH_BANK_ARB_HOLD_EN
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL sw_open_done: got %b want 0000", done); end
        tick(1);   // HOLD
        checks++; if (done !== 4'b0001 || lat_ena_n !== 8'hFF || busy !== 1'b1 || lat_data !== 8'hA5) begin
            errors++; $display("FAIL sw_hold: done=%b ena=%b busy=%b data=%h want 0001/11111111/1/a5", done, lat_ena_n, busy, lat_data);
        end
`else
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL sw_open_done: got %b want 0001", done); end
`endif
        tick(1);   // IDLE
        checks++; if (busy !== 1'b0 || done !== 4'b0000 || lat_ena_n !== 8'hFF || lat_data !== 8'hA5) begin
            errors++; $display("FAIL sw_idle: busy=%b done=%b ena=%b data=%h want 0/0000/11111111/a5", busy, done, lat_ena_n, lat_data);
        end
        $display("test_single_write done: checks=%0d errors=%0d", checks, errors);
    endtask

    // req=1111 held from reset: grants 0,1,2,3,0 spaced WCYC cycles apart.
    task automatic test_round_robin;
        int gidx[5];
        int gcyc[5];
        int expect_idx[5] = '{0, 1, 2, 3, 0};
        int n = 0;
        int cyc = 0;
        for (int i = 0; i < NREQ; i++) set_src(i, AW'(i + 1), 8'h10 + 8'(i));
        req = 4'b1111;
        do_reset;
        while (n < 5 && cyc < 60) begin
            tick(1);
            cyc++;
            if (gnt != 4'b0000) begin
                gidx[n] = -1;
                for (int i = 0; i < NREQ; i++) if (gnt[i]) gidx[n] = i;
                gcyc[n] = cyc;
                checks++; if (lat_data !== 8'h10 + 8'(gidx[n])) begin
                    errors++; $display("FAIL rr_data%0d: got %h want %h", n, lat_data, 8'h10 + 8'(gidx[n]));
                end
                n++;
            end
        end
        checks++; if (n != 5) begin errors++; $display("FAIL rr_timeout: got %0d grants want 5", n); end
        for (int k = 0; k < n; k++) begin
            checks++; if (gidx[k] != expect_idx[k]) begin
                errors++; $display("FAIL rr_order%0d: got %0d want %0d", k, gidx[k], expect_idx[k]);
            end
            if (k > 0) begin
                checks++; if (gcyc[k] - gcyc[k-1] != WCYC) begin
                    errors++; $display("FAIL rr_spacing%0d: got %0d want %0d", k, gcyc[k] - gcyc[k-1], WCYC);
                end
            end
        end
        $display("test_round_robin done: checks=%0d errors=%0d", checks, errors);
    endtask

    // After winner 2, req=0101 grants 0 then 2.
    task automatic test_priority;
        logic [NREQ-1:0] seen[2];
        int n = 0;
        int cyc = 0;
        req = 4'b0000;
        do_reset;
        set_src(0, 3'd1, 8'h11);
        set_src(2, 3'd6, 8'h22);
        req = 4'b0100;
        while (gnt == 4'b0000 && cyc < 10) begin tick(1); cyc++; end
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL pri_first: got %b want 0100", gnt); end
        req = 4'b0101;
        cyc = 0;
        while (n < 2 && cyc < 30) begin
            tick(1);
            cyc++;
            if (gnt != 4'b0000) begin seen[n] = gnt; n++; end
        end
        checks++; if (n != 2) begin errors++; $display("FAIL pri_timeout: got %0d grants want 2", n); end
        else begin
            checks++; if (seen[0] !== 4'b0001) begin errors++; $display("FAIL pri_second: got %b want 0001", seen[0]); end
            checks++; if (seen[1] !== 4'b0100) begin errors++; $display("FAIL pri_third: got %b want 0100", seen[1]); end
        end
        req = 4'b0000;
        tick(WCYC);
        $display("test_priority done: checks=%0d errors=%0d", checks, errors);
    endtask

    // Data change during OPEN does not reach lat_data until the next capture.
    task automatic test_data_hold;
        req = 4'b0000;
        do_reset;
        set_src(0, 3'd5, 8'hA5);
        req = 4'b0001;
        tick(2);   // OPEN
        checks++; if (lat_ena_n !== 8'b1101_1111 || lat_data !== 8'hA5) begin
            errors++; $display("FAIL dh_open: ena=%b data=%h want 11011111/a5", lat_ena_n, lat_data);
        end
        set_src(0, 3'd5, 8'h3C);
        req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checks++; if (lat_data !== 8'hA5) begin
                errors++; $display("FAIL dh_hold%0d: got %h want a5", k, lat_data);
            end
        end
        req = 4'b0001;
        tick(1);   // SETUP of the new write
        checks++; if (lat_data !== 8'h3C || gnt !== 4'b0001) begin
            errors++; $display("FAIL dh_next: data=%h gnt=%b want 3c/0001", lat_data, gnt);
        end
        req = 4'b0000;
        tick(WCYC);
        $display("test_data_hold done: checks=%0d errors=%0d", checks, errors);
    endtask

    // Reset during OPEN of requester 1: no done, requester 0 wins afterwards.
    task automatic test_reset_mid;
        int cyc = 0;
        bit saw_done = 1'b0;
        set_src(0, 3'd2, 8'h5A);
        set_src(1, 3'd4, 8'h6B);
        req = 4'b0011;
        do_reset;
        while (gnt !== 4'b0010 && cyc < 20) begin tick(1); cyc++; end
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rm_gnt1: got %b want 0010", gnt); end
        tick(1);   // OPEN of requester 1
        checks++; if (lat_ena_n !== 8'b1110_1111 || lat_data !== 8'h6B) begin
            errors++; $display("FAIL rm_open: ena=%b data=%h want 11101111/6b", lat_ena_n, lat_data);
        end
        reset = 1'b1;
        tick(1);
        checks++; if (lat_ena_n !== 8'hFF || busy !== 1'b0 || done !== 4'b0000 || gnt !== 4'b0000 || lat_data !== 8'h00) begin
            errors++; $display("FAIL rm_reset: ena=%b busy=%b done=%b gnt=%b data=%h want 11111111/0/0000/0000/00",
                               lat_ena_n, busy, done, gnt, lat_data);
        end
        reset = 1'b0;
        cyc = 0;
        do begin
            tick(1);
            cyc++;
            if (done != 4'b0000) saw_done = 1'b1;
        end while (gnt == 4'b0000 && cyc < 10);
        checks++; if (saw_done) begin errors++; $display("FAIL rm_nodone: got done pulse want none"); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rm_regrant: got %b want 0001", gnt); end
        req = 4'b0000;
        tick(WCYC);
        $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_round_robin;
        test_priority;
        test_data_hold;
        test_reset_mid;
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/latch_bank_arb.md
LATCH_BANK_ARB -- requirements
Module: latch_bank_arb

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requesters (2..8).
REQ-002 SHALL have parameter: AW, 3, latch-bank address width; NENT = 2**AW entries.
REQ-003 SHALL have parameter: DW, 8, latch data width.
REQ-004 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: req  input  NREQ  per-requester write request, level.
REQ-007 SHALL have port: req_addr  input  NREQ*AW  packed target entry per requester.
REQ-008 SHALL have port: req_data  input  NREQ*DW  packed write data per requester.
REQ-009 SHALL have port: gnt  output  NREQ  one-hot grant pulse, one cycle.
REQ-010 SHALL have port: done  output  NREQ  one-hot completion pulse, one cycle.
REQ-011 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port: lat_ena_n  output  NENT  active-low latch enables to the bank, at most one low.
REQ-013 SHALL have port: lat_data  output  DW  shared data bus to all bank latches.

Function
REQ-014 SHALL sequence FSM states IDLE -> SETUP -> OPEN -> HOLD -> IDLE, one cycle per state.
REQ-015 In IDLE with any req bit high, SHALL pick the winner round-robin, searching upward from last_winner+1 mod NREQ; SHALL capture the winner's addr/data into internal registers and go to SETUP.
REQ-016 In IDLE with req == 0, SHALL remain in IDLE; all outputs stay at reset values.
REQ-017 gnt[winner] SHALL be high exactly during the SETUP cycle; last_winner SHALL update on IDLE->SETUP.
REQ-018 SETUP: lat_data = captured data; all lat_ena_n high (data setup before enable).
REQ-019 OPEN: lat_ena_n[captured addr] = 0, all others 1; lat_data unchanged.
REQ-020 HOLD: all lat_ena_n high; lat_data still held; done[winner] high for this cycle only.
REQ-021 lat_data SHALL hold its last value in IDLE (no change while latches are closed).
REQ-022 Requesters SHALL hold req until done; deasserting req after grant SHALL NOT abort the transaction.
REQ-023 A requester holding req after its done SHALL compete again with lowest priority; IDLE always consumes one cycle between transactions (4 cycles per write with HOLD).
REQ-024 Input changes on req_addr/req_data after capture SHALL NOT affect the ongoing transaction.
REQ-025 gnt, done, lat_ena_n SHALL be driven from registers (glitch-free enables).

Reset
REQ-026 reset high at any clock edge, including mid-transaction, SHALL force state IDLE, lat_ena_n all 1, lat_data 0, gnt 0, done 0, busy 0, last_winner NREQ-1 (requester 0 wins first).
REQ-027 An interrupted transaction SHALL produce no done pulse; requester re-arbitrates normally.

Configuration
REQ-028 Macro LATCH_BANK_ARB_HOLD_EN defined: HOLD state present as above (4-cycle write).
REQ-029 Macro undefined: no HOLD state; OPEN -> IDLE, done[winner] pulses during OPEN (3-cycle write); all other behaviour identical.

Structure
REQ-030 Package latch_bank_pkg SHALL hold the FSM state enum (IDLE, SETUP, OPEN, HOLD) and default parameter constants.
REQ-031 Round-robin selection SHALL be sub-module rr_arbiter (inputs req, last_winner; output one-hot winner, combinational).

Verification
REQ-032 Reset then req=4'b0001, addr0=5, data0=8'hA5 -> gnt=0001 in SETUP, lat_ena_n[5]=0 one cycle in OPEN with lat_data=A5, done=0001 in HOLD.
REQ-033 req=4'b1111 held continuously from reset -> grants in order 0,1,2,3,0, one every 4 cycles (3 without HOLD_EN).
REQ-034 After winner 2, req=4'b0101 -> next grant goes to 0, then 2.
REQ-035 Change req_data0 to 8'h3C during OPEN of an A5 write -> lat_data stays A5 until next transaction.
REQ-036 Assert reset during OPEN -> next cycle lat_ena_n all 1, busy 0, no done; with req still high, requester 0 granted after reset release.
REQ-037 Every cycle assert: at most one lat_ena_n low, never low in SETUP/HOLD/IDLE; gnt and done each one-hot or zero.
